time_set_keypad: RTL

//  Converts three raw push-buttons into the BCD set-time digits and the set_time_finish

---
 rtl/clock_pkg.sv | 66 ++++++
 rtl/key_debounce.sv | 58 +++++
 rtl/time_set_keypad.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types and BCD helpers for the set-time keypad.
// Holds FSM states, edit-field codes and the 2-digit BCD stepper.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOUR,
    ST_MIN,
    ST_SEC,
    ST_COMMIT
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_HOUR = 2'd1,
    SEL_MIN  = 2'd2,
    SEL_SEC  = 2'd3
  } sel_e;

  typedef struct packed {
    logic mode;
    logic inc;
    logic dec;
  } key_ev_t;

  localparam logic [3:0] HOUR_MAX_SHI     = 4'd2;
  localparam logic [3:0] HOUR_MAX_GE_AT_2 = 4'd3;
  localparam logic [3:0] MINSEC_MAX_SHI   = 4'd5;
  localparam logic [3:0] GE_MAX           = 4'd9;

  localparam logic [7:0] HOUR_LIM =
    {HOUR_MAX_SHI, HOUR_MAX_GE_AT_2};
  localparam logic [7:0] MINSEC_LIM =
    {MINSEC_MAX_SHI, GE_MAX};

  // One wrap-around step of a {shi,ge} pair bounded by lim.
  function automatic logic [7:0] bcd_step(
    input logic [7:0] v,
    input logic       up,
    input logic [7:0] lim
  );
    logic [3:0] s;
    logic [3:0] g;
    logic [7:0] r;
    s = v[7:4];
    g = v[3:0];
    r = v;
    if (up) begin
      if (v == lim)
        r = 8'h00;
      else if (g == GE_MAX)
        r = {s + 4'd1, 4'd0};
      else
        r = {s, g + 4'd1};
    end else begin
      if (v == 8'h00)
        r = lim;
      else if (g == 4'd0)
        r = {s - 4'd1, GE_MAX};
      else
        r = {s, g - 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Key synchroniser, stability filter and press-edge pulse.
// Level follows the raw key only after a full run of equal samples.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          press_q;
  logic          press_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == LAST) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/time_set_keypad.sv
// Three-key time editor: snapshot, edit h/m/s in BCD, commit pulse.
// Idle edit states time out back to IDLE without committing.
import clock_pkg::*;

module time_set_keypad #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 500000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode_n,
  input  logic       key_inc_n,
  input  logic       key_dec_n,
  input  logic [3:0] cur_sec_ge,
  input  logic [3:0] cur_sec_shi,
  input  logic [3:0] cur_min_ge,
  input  logic [3:0] cur_min_shi,
  input  logic [3:0] cur_hour_ge,
  input  logic [3:0] cur_hour_shi,
  output logic [3:0] set_sec_ge,
  output logic [3:0] set_sec_shi,
  output logic [3:0] set_min_ge,
  output logic [3:0] set_min_shi,
  output logic [3:0] set_hour_ge,
  output logic [3:0] set_hour_shi,
  output logic       set_time_finish,
  output logic [1:0] edit_sel,
  output logic       editing
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TONE = TW'(1);

  key_ev_t       ev;
  logic          any_ev;
  logic          step_en;
  logic          step_up;

  state_e        state_q;
  state_e        state_d;
  logic [7:0]    hour_q;
  logic [7:0]    hour_d;
  logic [7:0]    min_q;
  logic [7:0]    min_d;
  logic [7:0]    sec_q;
  logic [7:0]    sec_d;
  logic [TW-1:0] to_q;
  logic [TW-1:0] to_d;
  logic          finish_q;
  logic          finish_d;
  sel_e          sel_q;
  sel_e          sel_d;
  logic          editing_q;
  logic          editing_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_mode (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n_i(key_mode_n),
    .press_o(ev.mode)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_inc (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n_i(key_inc_n),
    .press_o(ev.inc)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_dec (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n_i(key_dec_n),
    .press_o(ev.dec)
  );

  assign any_ev  = ev.mode | ev.inc | ev.dec;
  assign step_en = ev.inc ^ ev.dec;
  assign step_up = ev.inc;

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    to_d    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (ev.mode) begin
          state_d = ST_HOUR;
          hour_d  = {cur_hour_shi, cur_hour_ge};
          min_d   = {cur_min_shi, cur_min_ge};
          sec_d   = {cur_sec_shi, cur_sec_ge};
        end
      end
      ST_HOUR: begin
        if (ev.mode)
          state_d = ST_MIN;
        else if (step_en)
          hour_d = bcd_step(hour_q, step_up, HOUR_LIM);
      end
      ST_MIN: begin
        if (ev.mode)
          state_d = ST_SEC;
        else if (step_en)
          min_d = bcd_step(min_q, step_up, MINSEC_LIM);
      end
      ST_SEC: begin
        if (ev.mode)
          state_d = ST_COMMIT;
        else if (step_en)
          sec_d = bcd_step(sec_q, step_up, MINSEC_LIM);
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Any key event restarts the idle window; expiry aborts the edit.
    if (state_q inside {ST_HOUR, ST_MIN, ST_SEC}) begin
      if (any_ev)
        to_d = '0;
      else if (to_q == TLAST)
        state_d = ST_IDLE;
      else
        to_d = to_q + TONE;
    end

    finish_d  = (state_d == ST_COMMIT);
    editing_d = state_d inside {ST_HOUR, ST_MIN, ST_SEC};
    unique case (state_d)
      ST_HOUR: sel_d = SEL_HOUR;
      ST_MIN:  sel_d = SEL_MIN;
      ST_SEC:  sel_d = SEL_SEC;
      default: sel_d = SEL_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      hour_q    <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      to_q      <= '0;
      finish_q  <= 1'b0;
      sel_q     <= SEL_NONE;
      editing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      to_q      <= to_d;
      finish_q  <= finish_d;
      sel_q     <= sel_d;
      editing_q <= editing_d;
    end
  end

  assign set_hour_shi    = hour_q[7:4];
  assign set_hour_ge     = hour_q[3:0];
  assign set_min_shi     = min_q[7:4];
  assign set_min_ge      = min_q[3:0];
  assign set_sec_shi     = sec_q[7:4];
  assign set_sec_ge      = sec_q[3:0];
  assign set_time_finish = finish_q;
  assign edit_sel        = sel_q;
  assign editing         = editing_q;

endmodule
